// File: rtl/separador_pkg.sv
// separador_pkg: shared types, width helpers and anode polarity helper
package separador_pkg;
   typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_e;
   localparam int W_IN_DEF = 14;
   localparam int N_DIG_DEF = 4;
   localparam int DIV_DEF = 50000;
   function automatic int presc_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction
   function automatic int iter_w(input int w_in);
      return $clog2(w_in + 1);
   endfunction
   function automatic logic an_lvl(input logic sel, input logic active_low);
      return sel ^ active_low;
   endfunction
endpackage

// File: rtl/separador_multidigito_barrido.sv
// barrido_display: prescaled digit scanner with anode decode and leading-zero blanking
module barrido_display
   import separador_pkg::*;
#(
   parameter int N_DIG = N_DIG_DEF,
   parameter int DIV = DIV_DEF,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [4*N_DIG-1:0] disp,
   input  logic               ovf,
   input  logic               blank_lz,
   output logic [3:0]         bcd,
   output logic [N_DIG-1:0]   an
);
   localparam int PW = presc_w(DIV);
   localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [N_DIG-1:0] AN_RST = (AN_ACTIVE_LOW != 0) ? ~N_DIG'(1) : N_DIG'(1);
   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0] bcd_q, bcd_d;
   logic [N_DIG-1:0] an_q, an_d;
   logic wrap, blank;
   int msnz;
   always_comb begin
      wrap = presc_q == PW'(DIV - 1);
      presc_d = wrap ? '0 : presc_q + PW'(1);
      idx_d = !wrap ? idx_q : (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
      msnz = 0;
      for (int i = 1; i < N_DIG; i++) if (disp[4*i +: 4] != 4'd0) msnz = i;
      // outputs track the next index so bcd and an switch on the same edge as the index
      blank = blank_lz && !ovf && (int'(idx_d) > msnz);
      bcd_d = disp[4*idx_d +: 4];
      for (int i = 0; i < N_DIG; i++) an_d[i] = an_lvl(!blank && (idx_d == IW'(i)), AN_ACTIVE_LOW != 0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q <= '0;
         bcd_q <= '0;
         an_q <= AN_RST;
      end else begin
         presc_q <= presc_d;
         idx_q <= idx_d;
         bcd_q <= bcd_d;
         an_q <= an_d;
      end
   end
   assign bcd = bcd_q;
   assign an = an_q;
endmodule

// File: rtl/separador_multidigito.sv
// separador_multidigito: handshake-fed double-dabble converter with saturating display
// register feeding a multiplexed scan driver.
module separador_multidigito
   import separador_pkg::*;
#(
   parameter int W_IN = W_IN_DEF,
   parameter int N_DIG = N_DIG_DEF,
   parameter int DIV = DIV_DEF,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [W_IN-1:0]  in_val,
   output logic             in_ready,
   input  logic             blank_lz,
   output logic [3:0]       BCD,
   output logic [N_DIG-1:0] an,
   output logic             ovf
);
   localparam int IT_W = iter_w(W_IN);
   localparam int BW = 4 * N_DIG;
   conv_state_e state_q, state_d;
   logic [W_IN-1:0] bin_q, bin_d;
   logic [BW-1:0] scr_q, scr_d, disp_q, disp_d, adj;
   logic [IT_W-1:0] cnt_q, cnt_d;
   logic sovf_q, sovf_d, ovf_q, ovf_d, top;
   always_comb begin
      state_d = state_q;
      bin_d = bin_q;
      scr_d = scr_q;
      sovf_d = sovf_q;
      cnt_d = cnt_q;
      disp_d = disp_q;
      ovf_d = ovf_q;
      top = 1'b0;
      for (int i = 0; i < N_DIG; i++)
         adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
      case (state_q)
         IDLE: if (in_valid) begin
            bin_d = in_val;
            scr_d = '0;
            sovf_d = 1'b0;
            cnt_d = '0;
            state_d = CONV;
         end
         CONV: begin
            // a bit leaving the top digit means the value needs more digits than we have
            {top, scr_d, bin_d} = {adj, bin_q, 1'b0};
            sovf_d = sovf_q | top;
            cnt_d = cnt_q + IT_W'(1);
            if (cnt_q == IT_W'(W_IN - 1)) state_d = LOAD;
         end
         LOAD: begin
            disp_d = sovf_q ? {N_DIG{4'd9}} : scr_q;
            ovf_d = sovf_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q <= '0;
         scr_q <= '0;
         sovf_q <= 1'b0;
         cnt_q <= '0;
         disp_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q <= bin_d;
         scr_q <= scr_d;
         sovf_q <= sovf_d;
         cnt_q <= cnt_d;
         disp_q <= disp_d;
         ovf_q <= ovf_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign ovf = ovf_q;
   barrido_display #(
      .N_DIG(N_DIG),
      .DIV(DIV),
      .AN_ACTIVE_LOW(AN_ACTIVE_LOW)
   ) u_barrido (
      .clk(clk),
      .rst_n(rst_n),
      .disp(disp_q),
      .ovf(ovf_q),
      .blank_lz(blank_lz),
      .bcd(BCD),
      .an(an)
   );
endmodule

// File: tb/tb_separador_multidigito.sv
// tb_separador_multidigito: directed checks of conversion, scan, blanking, saturation and reset
module tb_separador_multidigito;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic blank_lz = 1'b0;
   logic [13:0] in_val = '0;
   logic in_ready, ovf;
   logic [3:0] bcd, an;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   separador_multidigito #(
      .W_IN(14),
      .N_DIG(4),
      .DIV(4),
      .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_val(in_val),
      .in_ready(in_ready),
      .blank_lz(blank_lz),
      .BCD(bcd),
      .an(an),
      .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [13:0] v);
      int n;
      @(negedge clk);
      in_val = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 16'(n), 16'd15);
      @(negedge clk);
   endtask

   task automatic scan(input string tag, input logic [15:0] dig, input logic [3:0] blk);
      int n;
      logic [3:0] e;
      n = 0;
      while (an !== 4'b1110 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_sync"}, 16'(n < 20), 16'd1);
      for (int i = 0; i < 4; i++) begin
         e = 4'b1 << i;
         e = blk[i] ? 4'b1111 : ~e;
         chk({tag, "_an"}, 16'(an), 16'(e));
         chk({tag, "_bcd"}, 16'(bcd), 16'(dig[4*i +: 4]));
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int slot;
      logic [15:0] w;
      repeat (2) @(negedge clk);
      chk("rst_an", 16'(an), 16'b1110);
      chk("rst_bcd", 16'(bcd), 16'd0);
      chk("rst_ready", 16'(in_ready), 16'd1);
      chk("rst_ovf", 16'(ovf), 16'd0);
      rst_n = 1'b1;
      n = 0;
      while (an !== 4'b1101 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idx_sync", 16'(n < 20), 16'd1);
      repeat (3) @(negedge clk);
      chk("idx_hold", 16'(an), 16'b1101);
      @(negedge clk);
      chk("idx_adv2", 16'(an), 16'b1011);
      repeat (4) @(negedge clk);
      chk("idx_adv3", 16'(an), 16'b0111);
      repeat (4) @(negedge clk);
      chk("idx_wrap", 16'(an), 16'b1110);

      send(14'd25);
      chk("v25_ovf", 16'(ovf), 16'd0);
      scan("v25", 16'h0025, 4'b0000);
      blank_lz = 1'b1;
      repeat (2) @(negedge clk);
      scan("v25b", 16'h0025, 4'b1100);
      send(14'd0);
      scan("v0b", 16'h0000, 4'b1110);
      send(14'd9999);
      chk("v9999_ovf", 16'(ovf), 16'd0);
      scan("v9999", 16'h9999, 4'b0000);
      send(14'd10000);
      chk("v10000_ovf", 16'(ovf), 16'd1);
      scan("v10000", 16'h9999, 4'b0000);
      blank_lz = 1'b0;

      @(negedge clk);
      in_val = 14'd1234;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_val = 14'd4321;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_gap", 16'(n + 1), 16'd16);
      @(posedge clk);
      #1 in_valid = 1'b0;
      w = 16'h1234;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         slot = (an == 4'b1110) ? 0 : (an == 4'b1101) ? 1 : (an == 4'b1011) ? 2 : (an == 4'b0111) ? 3 : -1;
         chk("b2b_onehot", 16'(slot >= 0), 16'd1);
         if (slot >= 0) chk("b2b_first", 16'(bcd), 16'(w[4*slot +: 4]));
      end
      n = 0;
      while (!in_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_done", 16'(in_ready), 16'd1);
      @(negedge clk);
      scan("v4321", 16'h4321, 4'b0000);
      chk("v4321_ovf", 16'(ovf), 16'd0);

      @(negedge clk);
      in_val = 14'd777;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 16'(in_ready), 16'd1);
      chk("mid_rst_an", 16'(an), 16'b1110);
      chk("mid_rst_bcd", 16'(bcd), 16'd0);
      chk("mid_rst_ovf", 16'(ovf), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(14'd42);
      scan("v42", 16'h0042, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/separador_multidigito.md
# separador_multidigito

Sequential binary-to-BCD separator with a multiplexed N-digit 7-segment scan driver. It accepts a W_IN-bit binary value through a valid/ready handshake and converts it with a shift-and-add-3 (double dabble) FSM. The result is committed atomically to a display register, which an independent prescaled scanner drives as one BCD digit plus a one-hot anode vector. It sits between the arithmetic/input logic and the BCD-to-7-segment decoder, and adds overflow saturation and leading-zero blanking.

## Interface
- W_IN, 14: binary input width.
- N_DIG, 4: number of display digits (≥1).
- DIV, 50000: clock cycles per digit slot (≥1).
- AN_ACTIVE_LOW, 1: 1 means an selected = 0 and deselected = 1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_val presented.
- in_val  in  W_IN  unsigned binary value.
- in_ready  out  1  converter idle, can accept.
- blank_lz  in  1  suppress leading zeros (sampled live by scanner).
- BCD  out  4  digit currently scanned.
- an  out  N_DIG  one-hot anode select, polarity per AN_ACTIVE_LOW.
- ovf  out  1  last committed value exceeded 10^N_DIG−1.

## Operation
- Converter FSM: IDLE → CONV → LOAD → IDLE.
- IDLE: in_ready=1. Accept when in_valid && in_ready, capture in_val into shift register, clear scratch BCD (4·N_DIG bits) and overflow flag.
- CONV: exactly W_IN iterations. Each iteration adds 3 to every scratch digit ≥5, then shifts left by 1. A 1 shifted out of the top digit sets the sticky overflow flag. in_valid and in_val are ignored.
- LOAD: copy scratch into display register and overflow flag into ovf. On overflow, the display register is loaded with all 9s instead.
- Scanner, independent of converter:
  - Prescaler counts 0..DIV−1. On wrap, the digit index advances 0→1→…→N_DIG−1→0.
  - BCD = display digit[index]; an = one-hot(index).
- Blanking: with blank_lz=1, a digit slot whose index is above the most significant nonzero digit drives an fully deselected. BCD still shows 0.
  - Digit 0 is never blanked.
  - When ovf=1, no digit is blanked.

## Timing
- Reset values:
  - FSM=IDLE, in_ready=1, ovf=0, display register all 0.
  - Prescaler=0, index=0, BCD=0, an selects digit 0 (4'b1110 for N_DIG=4, active low).
- Accept at edge k: in_ready=0 after k. CONV occupies edges k+1..k+W_IN. LOAD commits at edge k+W_IN+1, and in_ready=1 after that edge. Latency is W_IN+1 cycles.
- A new accept is possible at edge k+W_IN+2 (back-to-back, one idle cycle). Throughput is one conversion per W_IN+2 cycles.
- Display update is atomic at the LOAD edge. The scanner shows the old value until then and never shows partial conversions. The scanner phase is not disturbed by a commit.
- DIV=1: index advances every cycle. Index changes on the edge where prescaler == DIV−1.
- BCD and an are registered and change on the same edge.
- Reset asserted mid-CONV: immediate return to reset values. The pending conversion is discarded and the display returns to 0.

## Structure
- Package separador_pkg holds:
  - converter state enum (IDLE, CONV, LOAD);
  - AN polarity helper function;
  - localparams for prescaler width $clog2(DIV) (minimum 1) and iteration-counter width $clog2(W_IN+1).
- Sub-module barrido_display holds the prescaler, index, anode decode and blanking. It is parametrised by N_DIG, DIV and AN_ACTIVE_LOW, and takes the display register, ovf and blank_lz as inputs.
- The top level contains the converter FSM and the display register.

## Test plan
Bench: W_IN=14, N_DIG=4, DIV=4, AN_ACTIVE_LOW=1.
- Reset: hold rst_n=0 → an=1110, BCD=0, in_ready=1, ovf=0. Release → index advances every 4 cycles.
- in_val=25, one-cycle in_valid, blank_lz=0:
  - in_ready is 0 for 15 cycles.
  - After commit, the scan shows (an=1110, BCD=5), (1101, 2), (1011, 0), (0111, 0), repeating.
- in_val=25 with blank_lz=1 → slots 2 and 3 show an=1111; slots 0 and 1 unchanged. in_val=0 with blank_lz=1 → slot 0 shows an=1110, BCD=0, and the other slots show 1111.
- in_val=9999 → digits 9,9,9,9 with ovf=0. Then in_val=10000 → digits 9,9,9,9 with ovf=1 and no blanking with blank_lz=1.
- Back-to-back handshake:
  - in_valid held high with values 1234 then 4321 → two accepts 16 cycles apart.
  - The in_val change during CONV is ignored.
  - Display reads 1234, then 4321.
- Reset mid-conversion: rst_n pulsed low 5 cycles after accepting 777 → display 0 and in_ready=1 immediately. After release, accepting 42 shows 2,4,0,0.
